// File: rtl/cdb_slot_scheduler_if.sv
// Handshake bundle between the issue queues and the CDB slot scheduler.
// master = queue side (drives ready), slave = scheduler side (drives grants and CDB owner).
interface cdb_slot_scheduler_if;
  logic       ready_int;
  logic       ready_mult;
  logic       ready_div;
  logic       ready_mem;
  logic       issue_int;
  logic       issue_mult;
  logic       issue_div;
  logic       issue_mem;
  logic [3:0] cdb_sel;
  logic       cdb_valid;

  modport master (
    output ready_int, ready_mult, ready_div, ready_mem,
    input  issue_int, issue_mult, issue_div, issue_mem, cdb_sel, cdb_valid
  );

  modport slave (
    input  ready_int, ready_mult, ready_div, ready_mem,
    output issue_int, issue_mult, issue_div, issue_mem, cdb_sel, cdb_valid
  );
endinterface

// File: rtl/cdb_slot_scheduler.sv
// Common-data-bus slot scheduler: books the CDB cycle each unit will broadcast in,
// using an 8-entry shifting reservation register, and grants issue only into free slots.
module cdb_slot_scheduler #(
  parameter int LAT_INT  = 1,
  parameter int LAT_MEM  = 3,
  parameter int LAT_MULT = 3,
  parameter int LAT_DIV  = 6
) (
  input logic               clk,
  input logic               rst,
  cdb_slot_scheduler_if.slave bus
);

  localparam logic [1:0] ID_INT  = 2'd0;
  localparam logic [1:0] ID_MULT = 2'd1;
  localparam logic [1:0] ID_DIV  = 2'd2;
  localparam logic [1:0] ID_MEM  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } slot_t;

  slot_t [7:0] r_q, r_d, r_shift;
  logic  [2:0] div_busy_q, div_busy_d;
  logic        prio_mem_q, prio_mem_d;

  logic elig_int, elig_mult, elig_div, elig_mem;
  logic grant_int, grant_mult, grant_div, grant_mem;
  logic contested;
  logic [3:0] cdb_sel;

  // Grants are gated by rst so nothing issues while reset is held, whatever ready says.
  assign elig_int  = rst & bus.ready_int  & ~r_q[LAT_INT].valid;
  assign elig_mult = rst & bus.ready_mult & ~r_q[LAT_MULT].valid;
  assign elig_mem  = rst & bus.ready_mem  & ~r_q[LAT_MEM].valid;
  assign elig_div  = rst & bus.ready_div  & ~r_q[LAT_DIV].valid & (div_busy_q == 3'd0);

  assign contested  = elig_mem & elig_mult;
  assign grant_int  = elig_int;
  assign grant_div  = elig_div;
  assign grant_mem  = elig_mem  & (~elig_mult | prio_mem_q);
  assign grant_mult = elig_mult & (~elig_mem  | ~prio_mem_q);

  assign bus.issue_int  = grant_int;
  assign bus.issue_mult = grant_mult;
  assign bus.issue_div  = grant_div;
  assign bus.issue_mem  = grant_mem;

  for (genvar gi = 0; gi < 7; gi++) begin : g_shift
    assign r_shift[gi] = r_q[gi+1];
  end
  assign r_shift[7] = '0;

  // A grant books slot L-1 of the shifted register, i.e. the slot that was R[L] this cycle.
  always_comb begin
    r_d = r_shift;
    if (grant_int)  r_d[LAT_INT-1]  = {1'b1, ID_INT};
    if (grant_mult) r_d[LAT_MULT-1] = {1'b1, ID_MULT};
    if (grant_mem)  r_d[LAT_MEM-1]  = {1'b1, ID_MEM};
    if (grant_div)  r_d[LAT_DIV-1]  = {1'b1, ID_DIV};
  end

  always_comb begin
    div_busy_d = div_busy_q;
    if (grant_div) begin
      div_busy_d = 3'(LAT_DIV - 1);
    end else if (div_busy_q != 3'd0) begin
      div_busy_d = div_busy_q - 3'd1;
    end
  end

  always_comb begin
    prio_mem_d = prio_mem_q;
    if (contested) prio_mem_d = ~prio_mem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q        <= '0;
      div_busy_q <= 3'd0;
      prio_mem_q <= 1'b1;
    end else begin
      r_q        <= r_d;
      div_busy_q <= div_busy_d;
      prio_mem_q <= prio_mem_d;
    end
  end

  always_comb begin
    cdb_sel = 4'b0000;
    if (r_q[0].valid) cdb_sel[r_q[0].id] = 1'b1;
  end

  assign bus.cdb_sel   = cdb_sel;
  assign bus.cdb_valid = |cdb_sel;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Randomized bench for cdb_slot_scheduler against a calendar model: each absolute
// cycle number maps to the unit that owns the CDB in that cycle.
module tb_cdb_slot_scheduler;
  localparam int LI = 1;
  localparam int LM = 3;
  localparam int LU = 3;
  localparam int LD = 6;
  localparam int NCAL = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_slot_scheduler_if bus();

  cdb_slot_scheduler #(
    .LAT_INT(LI), .LAT_MEM(LM), .LAT_MULT(LU), .LAT_DIV(LD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Calendar: booked[c] is the one-hot owner {mem,div,mult,int} of the CDB in cycle c.
  logic [3:0] booked [NCAL];
  int         div_free_at = 0;
  bit         prio_mem    = 1'b1;
  logic [3:0] last_grant  = 4'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // rdy bit order: {mem, div, mult, int}
  task automatic step(input logic r, input logic [3:0] rdy);
    logic [3:0] exp_issue;
    logic [3:0] exp_cdb;
    bit e_int, e_mult, e_mem, e_div;
    @(posedge clk);
    #1;
    rst            = r;
    bus.ready_int  = rdy[0];
    bus.ready_mult = rdy[1];
    bus.ready_div  = rdy[2];
    bus.ready_mem  = rdy[3];
    exp_issue = 4'b0;
    if (!r) begin
      for (int c = cyc; c < NCAL; c++) booked[c] = 4'b0;
      div_free_at = 0;
      prio_mem    = 1'b1;
      exp_cdb     = 4'b0;
    end else begin
      exp_cdb = booked[cyc];
      e_int  = rdy[0] && booked[cyc+LI] == 4'b0;
      e_mult = rdy[1] && booked[cyc+LU] == 4'b0;
      e_mem  = rdy[3] && booked[cyc+LM] == 4'b0;
      e_div  = rdy[2] && booked[cyc+LD] == 4'b0 && cyc >= div_free_at;
      exp_issue[0] = e_int;
      exp_issue[2] = e_div;
      if (e_mem && e_mult) begin
        exp_issue[3] = prio_mem;
        exp_issue[1] = !prio_mem;
        prio_mem     = !prio_mem;
      end else begin
        exp_issue[3] = e_mem;
        exp_issue[1] = e_mult;
      end
    end
    @(negedge clk);
    check("issue", 32'({bus.issue_mem, bus.issue_div, bus.issue_mult, bus.issue_int}), 32'(exp_issue));
    check("cdb_sel", 32'(bus.cdb_sel), 32'(exp_cdb));
    check("cdb_valid", 32'(bus.cdb_valid), 32'(exp_cdb != 4'b0));
    if (exp_issue[0]) booked[cyc+LI] = 4'b0001;
    if (exp_issue[1]) booked[cyc+LU] = 4'b0010;
    if (exp_issue[2]) begin
      booked[cyc+LD] = 4'b0100;
      div_free_at    = cyc + LD;
    end
    if (exp_issue[3]) booked[cyc+LM] = 4'b1000;
    last_grant = exp_issue;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0000);
  endtask

  initial begin
    logic [3:0] pend;
    for (int c = 0; c < NCAL; c++) booked[c] = 4'b0;
    bus.ready_int  = 1'b0;
    bus.ready_mult = 1'b0;
    bus.ready_div  = 1'b0;
    bus.ready_mem  = 1'b0;
    #2 rst = 1'b0;

    // Reset held with all queues ready, then release.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111);
    step(1'b1, 4'b1111);
    drain(10);

    // Integer streaming.
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0001);
    drain(8);

    // mem/mult contention, each held until granted; done twice to see the flag flip.
    for (int rep = 0; rep < 2; rep++) begin
      pend = 4'b1010;
      for (int i = 0; i < 6 && pend != 4'b0; i++) begin
        step(1'b1, pend);
        pend = pend & ~last_grant;
      end
      drain(2);
      step(1'b1, 4'b1010);
      drain(8);
    end

    // Slot blocking of int by a mult booking.
    step(1'b1, 4'b0010);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0001);
    drain(8);

    // Divider occupancy, with a mult request landing on the div slot.
    for (int i = 0; i < 14; i++) step(1'b1, (i == 3 || i == 4) ? 4'b0110 : 4'b0100);
    drain(10);

    // Reset in the middle of outstanding bookings.
    step(1'b1, 4'b0110);
    step(1'b0, 4'b0000);
    drain(9);
    step(1'b1, 4'b0100);
    drain(8);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 149) != 0), 4'($urandom));
    end
    drain(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cdb_slot_scheduler.md
CDB_SLOT_SCHEDULER -- requirements
Module: cdb_slot_scheduler

Interface
REQ-001 SHALL have parameter LAT_INT, default 1, integer-unit latency in cycles from issue to CDB broadcast. Fixed at 1.
REQ-002 SHALL have parameter LAT_MEM, default 3, memory-unit latency.
REQ-003 SHALL have parameter LAT_MULT, default 3, multiplier latency. Must equal LAT_MEM.
REQ-004 SHALL have parameter LAT_DIV, default 6, divider latency. Range 2..7, and distinct from LAT_INT, LAT_MEM and LAT_MULT.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 ready_int, ready_mult, ready_div, ready_mem  input  1 each  the queue holds an instruction with all operands valid.
REQ-008 issue_int, issue_mult, issue_div, issue_mem  output  1 each  grant: the queue's head instruction enters its execution unit this cycle. Combinational from the ready inputs and registered state.
REQ-009 cdb_sel  output  4  one-hot CDB owner this cycle: bit0 int, bit1 mult, bit2 div, bit3 mem. Driven from a register.
REQ-010 cdb_valid  output  1  high when cdb_sel is nonzero.

Function
REQ-011 SHALL keep a reservation register R[0..7]. Each slot holds a valid bit and a 2-bit unit id. R[k] means the CDB is owned k cycles from now.
REQ-012 cdb_sel/cdb_valid SHALL be decoded from R[0] only.
REQ-013 A unit with latency L SHALL be eligible when its ready input is high and R[L] is invalid.
REQ-014 Each clock edge:
- R[k] <= R[k+1] for k = 0..6.
- R[7] <= invalid.
- Each granted unit writes {valid, id} into R[L-1].
REQ-015 Issue at cycle t SHALL put that unit on cdb_sel at exactly cycle t+L.
REQ-016 Contention between mem and mult (same latency, both eligible):
- Exactly one is granted.
- A 1-bit priority flag selects the winner and toggles after each contested grant.
- Reset value favours mem.
- An uncontested grant does not change the flag.
REQ-017 int and div SHALL never contend with each other or with mem/mult, because their latencies are distinct. Several grants in one cycle are legal.
REQ-018 Divider is non-pipelined: a div grant at cycle t SHALL load a 3-bit busy counter with LAT_DIV-1.
- The counter decrements each cycle down to 0.
- div is eligible only when the counter is 0, so the earliest next div grant is cycle t+LAT_DIV.
REQ-019 Grants SHALL never be asserted without the matching ready.
REQ-020 Two valid writes to the same R slot SHALL never occur.
REQ-021 A ready input may drop at any time without a grant. No state changes result.
REQ-022 The block SHALL NOT stall: if no unit is eligible, R simply shifts.

Reset
REQ-023 While rst=0:
- All R slots are invalid.
- The busy counter is 0.
- The priority flag favours mem.
- cdb_sel=0 and cdb_valid=0.
- All issue_* outputs are 0 regardless of the ready inputs.
REQ-024 Reset asserted mid-operation SHALL discard all pending reservations. No cdb_sel pulse may appear after rst returns high unless a new grant is made.
REQ-025 The first grant SHALL be possible in the first cycle in which rst=1.

Verification
REQ-026 Reset: hold ready_* = 1111 with rst=0 -> issue_* all 0, cdb_sel=0000. Release rst -> in the same cycle issue_int=1, issue_div=1, issue_mem=1, issue_mult=0.
REQ-027 Int streaming: ready_int=1 continuously from cycle t -> issue_int every cycle. cdb_sel=0001 from t+1 onward, with no gaps.
REQ-028 Contention: ready_mem and ready_mult both high from cycle t (hold each until granted) ->
- cycle t: issue_mem.
- cycle t+1: issue_mult.
- cdb_sel=1000 at t+3 and 0010 at t+4.
- The next contested cycle grants mult.
REQ-029 Slot blocking: mult granted at t, ready_int held high ->
- issue_int=0 at t+2 (R[1] holds mult).
- issue_int=1 at t+3.
- cdb_sel=0010 at t+3 and 0001 at t+4.
REQ-030 Divider occupancy: ready_div=1 continuously ->
- Grants at t, t+6, t+12 only.
- cdb_sel=0100 at t+6 and t+12.
- A mult request at t+3 is blocked (R[3]=div) and granted at t+4.
REQ-031 Reset mid-flight: grant mult and div at t, drive rst=0 at t+1 for one cycle -> cdb_sel stays 0000 through t+8, and the busy counter reads 0.
